// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - load handshake bundle for countdown_timer
interface countdown_timer_if #(
    parameter int Bits = 8
);
    logic            load_valid_i;
    logic            load_ready_o;
    logic [Bits-1:0] load_val_i;

    modport master (
        output load_valid_i,
        output load_val_i,
        input  load_ready_o
    );

    modport slave (
        input  load_valid_i,
        input  load_val_i,
        output load_ready_o
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with abort, done pulse and auto-reload
module countdown_timer #(
    parameter int Bits = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            abort_i,
    input  logic            auto_reload_i,
    countdown_timer_if.slave load_if,
    output logic [Bits-1:0] count_o,
    output logic            busy_o,
    output logic            done_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [Bits-1:0] r_count;
    logic [Bits-1:0] w_count_nxt;
    logic [Bits-1:0] r_reload;
    logic [Bits-1:0] w_reload_nxt;
    logic            w_xfer;
    logic            w_ready;

    assign w_xfer  = load_if.load_valid_i & w_ready;
    assign count_o = r_count;
    assign load_if.load_ready_o = w_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        if (w_xfer) begin
            w_reload_nxt = load_if.load_val_i;
        end
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_count_nxt = load_if.load_val_i;
                    w_state_nxt = (load_if.load_val_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // abort outranks enable; the count stops at 1 -> 0 so it can never wrap
                if (abort_i) begin
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (en_i) begin
                    if (r_count > Bits'(1)) begin
                        w_count_nxt = r_count - Bits'(1);
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (w_xfer) begin
                    w_count_nxt = load_if.load_val_i;
                    w_state_nxt = (load_if.load_val_i != '0) ? S_RUN : S_DONE;
                end else if (auto_reload_i) begin
                    w_count_nxt = r_reload;
                    w_state_nxt = (r_reload != '0) ? S_RUN : S_DONE;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_count_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o  = 1'b0;
        done_o  = 1'b0;
        w_ready = 1'b1;
        case (r_state)
            S_RUN: begin
                busy_o  = 1'b1;
                w_ready = 1'b0;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o  = 1'b0;
                done_o  = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
module tb_countdown_timer;
    localparam int B = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         abort = 1'b0;
    logic         ar = 1'b0;
    logic [B-1:0] count;
    logic         busy;
    logic         done;

    countdown_timer_if #(.Bits(B)) lif ();

    countdown_timer #(.Bits(B)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .abort_i       (abort),
        .auto_reload_i (ar),
        .load_if       (lif.slave),
        .count_o       (count),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // outputs packed as {count, busy, done, ready}
    function automatic int pk(input int c, input int b, input int d, input int r);
        return (c << 3) | (b << 2) | (d << 1) | r;
    endfunction

    function automatic int obs();
        return pk(int'(count), int'(busy), int'(done), int'(lif.load_ready_o));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic e, input logic a, input logic lv, input int v, input logic r);
        en = e;
        abort = a;
        lif.load_valid_i = lv;
        lif.load_val_i = B'(v);
        ar = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // reference: remaining count, whether we are counting, whether a finish cycle is showing
    int m_left, m_saved;
    bit m_counting, m_finished;

    function automatic void m_reset();
        m_left = 0; m_saved = 0; m_counting = 0; m_finished = 0;
    endfunction

    function automatic void m_start(input int v);
        m_saved = v;
        m_left = v;
        m_counting = (v != 0);
        m_finished = (v == 0);
    endfunction

    function automatic void m_step(input bit e, input bit a, input bit lv, input int v, input bit r);
        if (m_counting) begin
            if (a) begin
                m_left = 0; m_counting = 0;
            end else if (e) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_counting = 0; m_finished = 1;
                end
            end
        end else if (lv) begin
            m_start(v);
        end else if (m_finished && r) begin
            m_left = m_saved;
            m_counting = (m_saved != 0);
            m_finished = (m_saved == 0);
        end else begin
            m_left = 0; m_finished = 0;
        end
    endfunction

    function automatic int m_exp();
        return pk(m_left, int'(m_counting), int'(m_finished), int'(!m_counting));
    endfunction

    typedef struct {
        logic en, ab, lv;
        int   val;
        logic ar;
        int   ec, eb, ed, er;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic a, input logic lv, input int v, input logic r,
                                input int c, input int b, input int d, input int rd);
        vec_t t;
        t.en = e; t.ab = a; t.lv = lv; t.val = v; t.ar = r;
        t.ec = c; t.eb = b; t.ed = d; t.er = rd;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        int n;
        int pulses;
        bit ok;

        tbl.push_back(mk(0,0,1,4,0,   4,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,   3,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,   3,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,   3,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,   2,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,   1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,   0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,   0,0,0,1));
        tbl.push_back(mk(1,1,0,0,0,   0,0,0,1));
        tbl.push_back(mk(0,0,1,2,0,   2,1,0,0));
        tbl.push_back(mk(1,1,0,0,0,   0,0,0,1));
        tbl.push_back(mk(0,0,1,1,0,   1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,   0,0,1,1));
        tbl.push_back(mk(0,0,0,0,1,   1,1,0,0));
        tbl.push_back(mk(1,0,0,0,1,   0,0,1,1));
        tbl.push_back(mk(0,0,1,0,1,   0,0,1,1));
        tbl.push_back(mk(0,0,0,0,1,   0,0,1,1));
        tbl.push_back(mk(1,1,0,0,1,   0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,   0,0,0,1));
        tbl.push_back(mk(0,0,1,255,0, 255,1,0,0));
        tbl.push_back(mk(0,0,1,7,0,   255,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,   254,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,   0,0,0,1));

        set_in(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_state", obs(), pk(0, 0, 0, 1));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            set_in(tbl[i].en, tbl[i].ab, tbl[i].lv, tbl[i].val, tbl[i].ar);
            tick();
            chk($sformatf("table_row%0d", i), obs(), pk(tbl[i].ec, tbl[i].eb, tbl[i].ed, tbl[i].er));
        end

        // load 5, run to expiry, then idle
        do_reset();
        set_in(1, 0, 1, 5, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            lif.load_valid_i = 1'b0;
            if (k <= 6) chk($sformatf("load5_cycle%0d", k), obs(), pk(6 - k, (k < 6) ? 1 : 0, (k == 6) ? 1 : 0, (k == 6) ? 1 : 0));
            else        chk("load5_idle", obs(), pk(0, 0, 0, 1));
        end

        // auto-reload of 3: period of 4 cycles
        do_reset();
        set_in(1, 0, 1, 3, 1);
        pulses = 0;
        ok = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            lif.load_valid_i = 1'b0;
            if (done) pulses++;
            if (obs() != pk(3 - (k % 4), (k % 4 != 3) ? 1 : 0, (k % 4 == 3) ? 1 : 0, (k % 4 == 3) ? 1 : 0)) ok = 0;
        end
        chk("autoreload3_seq", int'(ok), 1);
        chk("autoreload3_pulses", pulses, 3);

        // load 200, abort at 150, then load 0
        do_reset();
        ar = 1'b0;
        set_in(1, 0, 1, 200, 0);
        tick();
        lif.load_valid_i = 1'b0;
        n = 0;
        while (count != 8'd150 && n < 300) begin
            tick();
            n++;
        end
        chk("abort_reach150_cycles", n, 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", obs(), pk(0, 0, 0, 1));
        set_in(1, 0, 1, 0, 0);
        tick();
        chk("load0_done", obs(), pk(0, 0, 1, 1));

        // load in DONE beats auto-reload, and sets the reload value
        set_in(1, 0, 1, 9, 1);
        tick();
        set_in(1, 0, 0, 0, 0);
        chk("done_load9", obs(), pk(9, 1, 0, 0));
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("run9_cycles", n, 9);
        ar = 1'b1;
        tick();
        ar = 1'b0;
        chk("reload_is9", obs(), pk(9, 1, 0, 0));

        // asynchronous reset mid-run, then full-range count
        do_reset();
        set_in(1, 0, 1, 255, 0);
        tick();
        lif.load_valid_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", obs(), pk(0, 0, 0, 1));
        set_in(1, 0, 1, 255, 0);
        #1;
        rst_n = 1'b1;
        tick();
        lif.load_valid_i = 1'b0;
        chk("post_reset_load", obs(), pk(255, 1, 0, 0));
        n = 1;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        chk("full_range_done_cycle", n, 256);
        chk("full_range_count0", int'(count), 0);

        // randomized run against the reference
        do_reset();
        m_reset();
        for (int k = 0; k < 4000; k++) begin
            logic e, a, lv, r;
            int v;
            e  = ($urandom_range(3) != 0);
            a  = ($urandom_range(15) == 0);
            lv = ($urandom_range(3) == 0);
            r  = $urandom_range(1);
            case ($urandom_range(7))
                0:       v = 0;
                1:       v = 255;
                2:       v = $urandom_range(255);
                default: v = $urandom_range(6);
            endcase
            set_in(e, a, lv, v, r);
            if (lif.load_ready_o !== logic'(!m_counting)) begin
                chk($sformatf("rand_ready_pre%0d", k), int'(lif.load_ready_o), int'(!m_counting));
            end
            m_step(e, a, lv, v, r);
            tick();
            chk($sformatf("rand_cycle%0d", k), obs(), m_exp());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: Bits, default 8, width of count and load value; SHALL be legal for Bits >= 2.
REQ-002 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 en_i  input  1  count enable; decrement occurs only in RUN with en_i=1.
REQ-005 abort_i  input  1  cancels RUN, returns to IDLE, no done pulse.
REQ-006 load_valid_i  input  1  load request; transfer on load_valid_i & load_ready_o at a rising edge.
REQ-007 load_val_i  input  Bits  start value; sampled only on transfer.
REQ-008 auto_reload_i  input  1  sampled in DONE; 1 = restart from stored reload value.
REQ-009 load_ready_o  output  1  high in IDLE and DONE, low in RUN.
REQ-010 count_o  output  Bits  current remaining count, registered.
REQ-011 busy_o  output  1  high exactly when state = RUN, registered/state-decoded.
REQ-012 done_o  output  1  high exactly when state = DONE (one cycle per expiry).

Function
REQ-013 States SHALL be IDLE, RUN, DONE; encoding free.
REQ-014 Internal reload register (Bits wide) SHALL capture load_val_i on every load transfer.
REQ-015 IDLE: on transfer with load_val_i != 0 -> count_o <= load_val_i, go RUN; with load_val_i = 0 -> count_o <= 0, go DONE; otherwise hold.
REQ-016 RUN, abort_i=1: count_o <= 0, go IDLE; abort_i has priority over en_i.
REQ-017 RUN, abort_i=0, en_i=0: count_o and state hold.
REQ-018 RUN, abort_i=0, en_i=1, count_o > 1: count_o <= count_o - 1, stay RUN.
REQ-019 RUN, abort_i=0, en_i=1, count_o = 1: count_o <= 0, go DONE.
REQ-020 Decrement SHALL never wrap: count_o SHALL never transition from 0 to all-ones.
REQ-021 DONE priority: load transfer first (same rules as REQ-015), else auto_reload_i=1 -> count_o <= reload register, go RUN (or stay DONE if reload register = 0), else go IDLE with count_o = 0.
REQ-022 abort_i and en_i SHALL be ignored in IDLE and DONE.
REQ-023 Load of N (N>0) with en_i held high: done_o asserts exactly N+1 cycles after transfer edge (N RUN cycles, then DONE).
REQ-024 Auto-reload with en_i held high: done_o period SHALL be N+1 cycles, no gap beyond the single DONE cycle.
REQ-025 Reload value 0 with auto_reload_i held high: done_o SHALL stay high continuously.
REQ-026 Load value N = 2^Bits-1 SHALL count the full range without truncation.

Reset
REQ-027 rst_ni=0 SHALL immediately force state IDLE, count_o=0, reload register=0, busy_o=0, done_o=0, load_ready_o=1, independent of clk_i.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the count with no done pulse; after release the block is in IDLE.
REQ-029 First load transfer SHALL be accepted at the first rising edge after rst_ni deasserts.

Verification
REQ-030 Bits=8, load 5, en_i=1, auto_reload_i=0 -> count_o 5,4,3,2,1,0; done_o high one cycle 6 cycles after transfer; then IDLE, load_ready_o=1.
REQ-031 Load 4, toggle en_i 1,0,0,1,1,1 -> count_o 3,3,3,2,1,0 with done_o on the cycle after count_o reaches 0 via REQ-019; hold cycles add delay 1:1.
REQ-032 Load 3, auto_reload_i=1 for 3 periods -> done_o pulses every 4 cycles; count_o sequence 3,2,1,0,3,2,1,0,...
REQ-033 Load 200, en_i=1, abort_i at count 150 -> next cycle IDLE, count_o=0, no done_o; load 0 -> done_o next cycle.
REQ-034 In DONE with auto_reload_i=1 and load_valid_i=1, load_val_i=9 -> new load wins, count_o=9, reload register=9.
REQ-035 Load 255, rst_ni pulsed low asynchronously mid-RUN (between edges) -> outputs reset immediately per REQ-027; load 255 with en_i=1 -> done_o 256 cycles after transfer.
